// File: rtl/mips_fetch_pkg.sv
// Shared types, reset/halt defaults and the byte-swap helper for the instruction fetch stage.
package mips_fetch_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RESP,
      HOLD,
      HALT
   } fetch_state_t;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
   localparam logic [XLEN-1:0] HALT_ADDR_DEF    = 32'h0000_0000;

   // Reverse byte order of a word fetched over a little-endian byte-addressed bus.
   function automatic logic [XLEN-1:0] byte_swap32(input logic [XLEN-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: issues instruction reads for pc_in, buffers one instruction for decode,
// and pulses the PC clock-enable on consumption. FETCH_ENDIAN_SWAP_EN byte-reverses fetched words.
module instr_fetch
   import mips_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [XLEN-1:0] HALT_ADDR    = HALT_ADDR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_enable,
   output logic [XLEN-1:0] mem_address,
   output logic            mem_read,
   input  logic            mem_waitrequest,
   input  logic [XLEN-1:0] mem_readdata,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic            active,
   output logic            fault
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic            instr_valid_q, instr_valid_d;
   logic            active_q, active_d;
   logic            fault_q, fault_d;

   logic [XLEN-1:0] rd_word;
   logic            pc_is_halt;
   logic            pc_misaligned;

`ifdef FETCH_ENDIAN_SWAP_EN
   assign rd_word = byte_swap32(mem_readdata);
`else
   assign rd_word = mem_readdata;
`endif

   assign pc_is_halt    = (pc_in == HALT_ADDR);
   assign pc_misaligned = (pc_in[1:0] != 2'b00);

   // Next-state and bus/handshake control; mem_read, mem_address and pc_enable follow the
   // current state directly so the request tracks pc_in in the same cycle the PC updates.
   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      active_d      = active_q;
      fault_d       = fault_q;
      mem_read      = 1'b0;
      mem_address   = '0;
      pc_enable     = 1'b0;

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (pc_is_halt) begin
               active_d = 1'b0;
               state_d  = HALT;
            end else if (pc_misaligned) begin
               fault_d  = 1'b1;
               active_d = 1'b0;
               state_d  = HALT;
            end else begin
               mem_read    = 1'b1;
               mem_address = {pc_in[XLEN-1:2], 2'b00};
               if (!mem_waitrequest) begin
                  instr_pc_d = pc_in;
                  state_d    = RESP;
               end
            end
         end
         RESP: begin
            instr_d       = rd_word;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
         end
         HOLD: begin
            if (instr_ready) begin
               pc_enable     = 1'b1;
               instr_valid_d = 1'b0;
               state_d       = REQ;
            end
         end
         HALT: begin
            active_d      = 1'b0;
            instr_valid_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         instr_q       <= '0;
         instr_pc_q    <= RESET_VECTOR;
         instr_valid_q <= 1'b0;
         active_q      <= 1'b1;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         active_q      <= active_d;
         fault_q       <= fault_d;
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign active      = active_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a bus/PC model and an instruction scoreboard.
// Honours FETCH_ENDIAN_SWAP_EN when computing expected instruction words.
module tb_instr_fetch;

   logic        clk;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_enable;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        active;
   logic        fault;

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_enable      (pc_enable),
      .mem_address    (mem_address),
      .mem_read       (mem_read),
      .mem_waitrequest(mem_waitrequest),
      .mem_readdata   (mem_readdata),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .active         (active),
      .fault          (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          pe_cnt = 0;
   int          hs_cnt = 0;
   logic        acc, pe, hs, in_reset;
   logic [31:0] acc_addr;
   logic        halt_next = 1'b0;

   // Instruction memory contents seen on the bus.
   function automatic logic [31:0] raw_word(input logic [31:0] addr);
      case (addr)
         32'hBFC0_0000: return 32'h2402_0005;
         32'hBFC0_0010: return 32'h0500_0224;
         default:       return {addr[15:0], ~addr[15:0]};
      endcase
   endfunction

   function automatic logic [31:0] exp_instr(input logic [31:0] raw);
`ifdef FETCH_ENDIAN_SWAP_EN
      return {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
      return raw;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Settle combinational outputs, then record bus acceptance and decode handshake.
   task automatic look();
      exp_t e;
      #1;
      in_reset = (reset === 1'b1);
      acc = (mem_read === 1'b1) && (mem_waitrequest === 1'b0) && !in_reset;
      pe  = (pc_enable === 1'b1) && !in_reset;
      hs  = (instr_valid === 1'b1) && (instr_ready === 1'b1) && !in_reset;
      if (!in_reset) chk("pc_enable_vs_handshake", {31'd0, pc_enable}, {31'd0, hs});
      if (mem_read === 1'b1) chk("mem_address_align", mem_address, {pc_in[31:2], 2'b00});
      if (acc) begin
         acc_addr = mem_address;
         sb.push_back('{word: exp_instr(raw_word({pc_in[31:2], 2'b00})), pc: pc_in});
      end
      if (hs) begin
         hs_cnt++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_underflow: observed instr %08h expected no instruction", instr);
         end else begin
            e = sb.pop_front();
            chk("sb_instr", instr, e.word);
            chk("sb_instr_pc", instr_pc, e.pc);
         end
      end
      if (pe) pe_cnt++;
   endtask

   // Clock edge, then the PC register and memory respond.
   task automatic adv();
      @(posedge clk);
      #1;
      if (pe) pc_in = halt_next ? 32'h0 : pc_in + 32'd4;
      mem_readdata = acc ? raw_word(acc_addr) : 32'hDEAD_BEEF;
   endtask

   task automatic cyc();
      look();
      adv();
   endtask

   task automatic do_reset(input logic [31:0] pc);
      reset = 1'b1;
      pc_in = pc;
      mem_waitrequest = 1'b0;
      instr_ready = 1'b0;
      cyc();
      cyc();
      sb.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
      chk({tag, "_mem_address"}, mem_address, 32'd0);
      chk({tag, "_pc_enable"}, {31'd0, pc_enable}, 32'd0);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_instr_pc"}, instr_pc, 32'hBFC0_0000);
      chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_active"}, {31'd0, active}, 32'd1);
      chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] e_endian;
      int base_pe;
      reset = 1'b1;
      pc_in = 32'hBFC0_0000;
      mem_waitrequest = 1'b0;
      mem_readdata = 32'hDEAD_BEEF;
      instr_ready = 1'b0;
      @(posedge clk);
      #1;

      // Reset values and basic fetch
      do_reset(32'hBFC0_0000);
      look(); chk_reset_vals("rst"); adv();
      reset = 1'b0;
      instr_ready = 1'b1;
      look(); chk("idle_mem_read", {31'd0, mem_read}, 32'd0); adv();
      look(); chk("req_mem_read", {31'd0, mem_read}, 32'd1);
              chk("req_addr", mem_address, 32'hBFC0_0000); adv();
      look(); chk("resp_mem_read", {31'd0, mem_read}, 32'd0);
              chk("resp_valid", {31'd0, instr_valid}, 32'd0); adv();
      look(); chk("hold_valid", {31'd0, instr_valid}, 32'd1);
              chk("hold_instr", instr, exp_instr(32'h2402_0005));
              chk("hold_pc_enable", {31'd0, pc_enable}, 32'd1); adv();
      mem_waitrequest = 1'b1;
      look(); chk("basic_pe_count", 32'(pe_cnt), 32'd1);
              chk("next_valid", {31'd0, instr_valid}, 32'd0); adv();

      // Wait states on the second fetch
      for (int i = 0; i < 3; i++) begin
         look(); chk("ws_read", {31'd0, mem_read}, 32'd1);
                 chk("ws_addr", mem_address, 32'hBFC0_0004);
                 chk("ws_valid", {31'd0, instr_valid}, 32'd0); adv();
      end
      mem_waitrequest = 1'b0;
      instr_ready = 1'b0;
      look(); chk("ws_accept_read", {31'd0, mem_read}, 32'd1);
              chk("ws_accept_addr", mem_address, 32'hBFC0_0004); adv();
      look(); chk("ws_resp_valid", {31'd0, instr_valid}, 32'd0); adv();

      // Back-pressure: six cycles in HOLD with instr_ready low
      for (int i = 0; i < 6; i++) begin
         mem_waitrequest = i[0];
         look(); chk("bp_valid", {31'd0, instr_valid}, 32'd1);
                 chk("bp_instr", instr, exp_instr(raw_word(32'hBFC0_0004)));
                 chk("bp_instr_pc", instr_pc, 32'hBFC0_0004);
                 chk("bp_pc_enable", {31'd0, pc_enable}, 32'd0);
                 chk("bp_mem_read", {31'd0, mem_read}, 32'd0); adv();
      end
      mem_waitrequest = 1'b0;
      instr_ready = 1'b1;
      base_pe = pe_cnt;
      look(); chk("bp_release_pe", {31'd0, pc_enable}, 32'd1); adv();
      look(); chk("bp_single_pulse", 32'(pe_cnt - base_pe), 32'd1);
              chk("bp_next_addr", mem_address, 32'hBFC0_0008); adv();

      // Random waitrequest / ready traffic, then steer the PC to the halt address
      for (int c = 0; c < 80; c++) begin
         mem_waitrequest = 1'($urandom_range(0, 1));
         instr_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      chk("rand_pe_eq_consumed", 32'(pe_cnt), 32'(hs_cnt));
      halt_next = 1'b1;
      mem_waitrequest = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 20 && active !== 1'b0; i++) cyc();
      halt_next = 1'b0;
      chk("pc_halt_active", {31'd0, active}, 32'd0);
      chk("pc_halt_sb_empty", 32'(sb.size()), 32'd0);

      // Halt address on entry to REQ
      do_reset(32'h0000_0000);
      look(); adv();
      reset = 1'b0;
      look(); chk("h_idle_active", {31'd0, active}, 32'd1); adv();
      look(); chk("h_req_read", {31'd0, mem_read}, 32'd0); adv();
      for (int i = 0; i < 4; i++) begin
         instr_ready = i[0];
         look(); chk("h_active", {31'd0, active}, 32'd0);
                 chk("h_pc_enable", {31'd0, pc_enable}, 32'd0);
                 chk("h_mem_read", {31'd0, mem_read}, 32'd0);
                 chk("h_valid", {31'd0, instr_valid}, 32'd0);
                 chk("h_fault", {31'd0, fault}, 32'd0); adv();
      end

      // Misaligned PC
      do_reset(32'hBFC0_0002);
      look(); adv();
      reset = 1'b0;
      instr_ready = 1'b1;
      look(); chk("m_idle_fault", {31'd0, fault}, 32'd0); adv();
      look(); chk("m_req_read", {31'd0, mem_read}, 32'd0); adv();
      for (int i = 0; i < 3; i++) begin
         look(); chk("m_fault", {31'd0, fault}, 32'd1);
                 chk("m_active", {31'd0, active}, 32'd0);
                 chk("m_pc_enable", {31'd0, pc_enable}, 32'd0); adv();
      end

      // Reset while in RESP; stale response must not reach instr
      do_reset(32'hBFC0_0010);
      look(); adv();
      reset = 1'b0;
      instr_ready = 1'b0;
      look(); adv();
      look(); chk("r_req_read", {31'd0, mem_read}, 32'd1); adv();
      reset = 1'b1;
      look(); chk("r_resp_valid", {31'd0, instr_valid}, 32'd0); adv();
      sb.delete();
      look(); chk_reset_vals("r_mid"); adv();
      reset = 1'b0;

      // Endian handling on a normal fetch of the same word
      e_endian =
`ifdef FETCH_ENDIAN_SWAP_EN
         32'h2402_0005;
`else
         32'h0500_0224;
`endif
      look(); chk("e_idle_instr", instr, 32'd0); adv();
      look(); chk("e_req_read", {31'd0, mem_read}, 32'd1); adv();
      look(); adv();
      instr_ready = 1'b1;
      look(); chk("e_valid", {31'd0, instr_valid}, 32'd1);
              chk("e_instr", instr, e_endian);
              chk("e_instr_pc", instr_pc, 32'hBFC0_0010); adv();
      chk("sb_final_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
